memfill_dma: RTL
================

MEMFILL_DMA -- requirements
Module: memfill_dma

Interface
REQ-001 Parameter STROBE_CYCLES, default 1, sets the number of cycles WE_n is held low per byte (legal range 1-4).
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 irq  output  1  completion interrupt, level, active-high.
REQ-005 AD  input  4  CPU register select.
REQ-006 DI  input  8  CPU write data.
REQ-007 DO  output  8  CPU read data, combinational from AD.
REQ-008 rw  input  1  1 = CPU read, 0 = CPU write.
REQ-009 cs  input  1  register select qualified by VMA.
REQ-010 hold  output  1  bus request; stalls the CPU while 1.
REQ-011 WADDR  output  16  external SRAM write address.
REQ-012 WDATA  output  8  external SRAM write data.
REQ-013 WE_n  output  1  SRAM write strobe, active-low.

Function
REQ-014 The register write SHALL occur on the rising edge where cs=1 and rw=0. Map: 0 ADDR_H, 1 ADDR_L, 2 CNT_H, 3 CNT_L, 4 FILL, 5 STEP, 6 CTRL, 7 STATUS (read-only). Reads of 8-15 return $FF.
REQ-015 CTRL bits: b0 START (write-1 pulse), b1 IEN, b2 INCV (FILL increments after each byte), b3 ABORT (write-1 pulse). A CTRL read SHALL return {5'b0, INCV, IEN, 1'b0}.
REQ-016 STATUS bits: b0 BUSY, b1 DONE, b2 ABORTED, others 0. A CPU read of STATUS SHALL clear DONE and ABORTED on that edge.
REQ-017 Reads of ADDR, CNT, and FILL SHALL return live working values; they change during a transfer.
REQ-018 The FSM states SHALL be IDLE, SETUP, STROBE, FINISH.
REQ-019 IDLE: a START write with CNT!=0 SHALL enter SETUP on the next edge, with hold=1 from that cycle onward.
REQ-020 IDLE: a START write with CNT=0 SHALL enter FINISH directly; no hold and no strobe occur.
REQ-021 SETUP: lasts 1 cycle, with WADDR=ADDR, WDATA=FILL, WE_n=1, then goes to STROBE.
REQ-022 STROBE: lasts STROBE_CYCLES cycles with WE_n=0; WADDR and WDATA stay stable throughout.
REQ-023 On leaving STROBE: ADDR += STEP (mod 2^16, wraps $FFFF->$0000); CNT -= 1; FILL += 1 (mod 256) if INCV.
REQ-024 On leaving STROBE: go to SETUP if the new CNT!=0 and no abort is pending; otherwise go to FINISH.
REQ-025 Each byte SHALL take 1+STROBE_CYCLES cycles.
REQ-026 STEP=0 SHALL write the same address repeatedly.
REQ-027 FINISH: lasts 1 cycle with hold=0 and WE_n=1; sets DONE (or ABORTED if the abort was pending), then returns to IDLE.
REQ-028 hold SHALL be 1 exactly in SETUP and STROBE.
REQ-029 BUSY SHALL be 1 in all states except IDLE.
REQ-030 While BUSY, writes to regs 0-5 and START SHALL be ignored; the ABORT and IEN bits remain writable.
REQ-031 ABORT in IDLE SHALL be a no-op.
REQ-032 ABORT while busy SHALL be latched as pending and take effect only at the end of the current STROBE; a WE_n pulse is never truncated.
REQ-033 ABORT during SETUP SHALL still complete that byte.
REQ-034 irq SHALL equal (DONE | ABORTED) & IEN.
REQ-035 If a STATUS read coincides with the FINISH set, the set SHALL win.
REQ-036 WE_n SHALL be 1 whenever hold=0.
REQ-037 When hold=0, WADDR and WDATA are don't-care but must not glitch WE_n.

Reset
REQ-038 On rst=1 at an edge: state=IDLE; hold=0; WE_n=1; irq=0; ADDR=CNT=FILL=$0000/$00; STEP=1; IEN=INCV=0; DONE=ABORTED=0; abort-pending cleared.
REQ-039 Reset mid-transfer SHALL release hold and WE_n on the same edge.

Verification
REQ-040 Setup: ADDR=$2000, CNT=3, FILL=$AA, STEP=1, STROBE_CYCLES=1, START. Required: hold high for 6 cycles; WE_n pulses at $2000, $2001, $2002, each with data $AA; then DONE=1, ADDR=$2003, CNT=0.
REQ-041 Setup: INCV=1, IEN=1, ADDR=$FFFE, CNT=3, FILL=$FF. Required: writes $FFFE=$FF, $FFFF=$00, $0000=$01; irq rises after FINISH; a STATUS read returns $02 and clears irq.
REQ-042 Setup: CNT=0, START. Required: hold and WE_n never assert; DONE=1 two edges after the write.
REQ-043 Setup: CNT=10, ABORT written during byte 4 SETUP. Required: byte 4 is written completely; hold drops; STATUS=$04; CNT=6.
REQ-044 Setup: while busy, write ADDR_L=$55 and START. Required: both are ignored and the transfer is unchanged. Then assert rst mid-STROBE. Required: hold=0, WE_n=1 on the next edge; all registers hold reset values.

Source files
------------

// File: rtl/memfill_dma_if.sv
// CPU register port and SRAM write port of the memory-fill DMA engine.
// The slave modport is the engine's view; master is the CPU/SRAM side.
interface memfill_dma_if;
    logic [3:0]  AD;
    logic [7:0]  DI;
    logic [7:0]  DO;
    logic        rw;
    logic        cs;
    logic [15:0] WADDR;
    logic [7:0]  WDATA;
    logic        WE_n;

    modport slave (
        input  AD, DI, rw, cs,
        output DO, WADDR, WDATA, WE_n
    );

    modport master (
        output AD, DI, rw, cs,
        input  DO, WADDR, WDATA, WE_n
    );
endinterface

// File: rtl/memfill_dma.sv
// Memory-fill DMA: stalls the CPU with hold and writes FILL to CNT consecutive
// SRAM locations starting at ADDR, stepping by STEP, with an optional abort.
module memfill_dma #(
    parameter int unsigned STROBE_CYCLES = 1
) (
    input  logic                clk,
    input  logic                rst,
    memfill_dma_if.slave        bus,
    output logic                hold,
    output logic                irq
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        FINISH = 2'd3
    } state_t;

    localparam logic [2:0] STRB_LAST = 3'(STROBE_CYCLES - 32'd1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_addr;
    logic [15:0] r_cnt;
    logic [7:0]  r_fill;
    logic [7:0]  r_step;
    logic        r_ien;
    logic        r_incv;
    logic        r_done;
    logic        r_aborted;
    logic        r_abort_pend;
    logic [2:0]  r_strb_cnt;
    logic        r_hold;
    logic        r_we_n;

    logic        w_wr;
    logic        w_rd;
    logic        w_busy;
    logic        w_ctrl_wr;
    logic        w_start;
    logic        w_abort;
    logic        w_strb_last;
    logic [15:0] w_cnt_dec;
    logic [7:0]  w_do;

    assign w_wr        = bus.cs & ~bus.rw;
    assign w_rd        = bus.cs &  bus.rw;
    assign w_busy      = (r_state != IDLE);
    assign w_ctrl_wr   = w_wr && (bus.AD == 4'd6);
    assign w_start     = w_ctrl_wr && bus.DI[0] && !w_busy;
    assign w_abort     = w_ctrl_wr && bus.DI[3] && w_busy;
    assign w_strb_last = (r_state == STROBE) && (r_strb_cnt == STRB_LAST);
    assign w_cnt_dec   = r_cnt - 16'd1;

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_state_nxt = (r_cnt != 16'd0) ? SETUP : FINISH;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            SETUP:  w_state_nxt = STROBE;
            STROBE: begin
                if (!w_strb_last) begin
                    w_state_nxt = STROBE;
                end else if ((w_cnt_dec != 16'd0) && !r_abort_pend && !w_abort) begin
                    w_state_nxt = SETUP;
                end else begin
                    w_state_nxt = FINISH;
                end
            end
            FINISH:  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register; hold and WE_n are registered from the next state so reset drops them at once
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_hold  <= 1'b0;
            r_we_n  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_hold  <= (w_state_nxt == SETUP) || (w_state_nxt == STROBE);
            r_we_n  <= (w_state_nxt != STROBE);
        end
    end

    // Register file, working counters and completion flags
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr       <= 16'h0000;
            r_cnt        <= 16'h0000;
            r_fill       <= 8'h00;
            r_step       <= 8'h01;
            r_ien        <= 1'b0;
            r_incv       <= 1'b0;
            r_done       <= 1'b0;
            r_aborted    <= 1'b0;
            r_abort_pend <= 1'b0;
            r_strb_cnt   <= 3'd0;
        end else begin
            if ((r_state == STROBE) && !w_strb_last) begin
                r_strb_cnt <= r_strb_cnt + 3'd1;
            end else begin
                r_strb_cnt <= 3'd0;
            end

            if (w_wr && !w_busy) begin
                case (bus.AD)
                    4'd0:    r_addr[15:8] <= bus.DI;
                    4'd1:    r_addr[7:0]  <= bus.DI;
                    4'd2:    r_cnt[15:8]  <= bus.DI;
                    4'd3:    r_cnt[7:0]   <= bus.DI;
                    4'd4:    r_fill       <= bus.DI;
                    4'd5:    r_step       <= bus.DI;
                    4'd6:    r_incv       <= bus.DI[2];
                    default: r_incv       <= r_incv;
                endcase
            end

            if (w_ctrl_wr) begin
                r_ien <= bus.DI[1];
            end

            if (w_strb_last) begin
                r_addr <= r_addr + {8'h00, r_step};
                r_cnt  <= w_cnt_dec;
                if (r_incv) begin
                    r_fill <= r_fill + 8'd1;
                end
            end

            // Pending abort is consumed by FINISH, so it never leaks into the next transfer
            if (r_state == FINISH) begin
                r_abort_pend <= 1'b0;
            end else if (w_abort) begin
                r_abort_pend <= 1'b1;
            end

            if (w_rd && (bus.AD == 4'd7)) begin
                r_done    <= 1'b0;
                r_aborted <= 1'b0;
            end
            if (r_state == FINISH) begin
                if (r_abort_pend) begin
                    r_aborted <= 1'b1;
                end else begin
                    r_done    <= 1'b1;
                end
            end
        end
    end

    // CPU read mux
    always_comb begin
        w_do = 8'hFF;
        case (bus.AD)
            4'd0:    w_do = r_addr[15:8];
            4'd1:    w_do = r_addr[7:0];
            4'd2:    w_do = r_cnt[15:8];
            4'd3:    w_do = r_cnt[7:0];
            4'd4:    w_do = r_fill;
            4'd5:    w_do = r_step;
            4'd6:    w_do = {5'b00000, r_incv, r_ien, 1'b0};
            4'd7:    w_do = {5'b00000, r_aborted, r_done, w_busy};
            default: w_do = 8'hFF;
        endcase
    end

    assign bus.DO    = w_do;
    assign bus.WADDR = r_addr;
    assign bus.WDATA = r_fill;
    assign bus.WE_n  = r_we_n;
    assign hold      = r_hold;
    assign irq       = (r_done | r_aborted) & r_ien;

endmodule
